wm_result_writeback: RTL and testbench
======================================

Name: wm_result_writeback

Overview:
- Sequencer that copies the final per-node distance vector from Working Memory into Output Memory once the Bellman-Ford relaxation has finished.
- Each 128-bit Working Memory word packs 8 distances of 16 bits each. The block reads one word, then writes its 8 lanes one per cycle through the Output Memory write port.
- Sits beside the bellmanford core. It is the sole driver of the Output Memory write port and of one Working Memory read port while busy.

Parameters:
- LANES, 8, 16-bit distance lanes per Working Memory word; fixed by the 128-bit word.
- AW, 13, address width for both memories.
- DW, 16, distance width.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- node_count  input  13  number of distances to copy; sampled with start.
- wm_base  input  13  Working Memory word address of node 0's word; sampled with start.
- om_base  input  13  Output Memory address for node 0; sampled with start.
- WMAR  output  13  Working Memory read address.
- WMDR  input  128  Working Memory read data; combinational, valid in the same cycle as WMAR.
- OMWAR  output  13  Output Memory write address.
- OMWDR  output  16  Output Memory write data.
- OMWE  output  1  Output Memory write enable; write occurs on the rising edge while high.
- busy  output  1  high in LOAD and WRITE states.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset, takes effect on any cycle including mid-operation:
  - state=IDLE.
  - WMAR=0, OMWAR=0, OMWDR=0, OMWE=0, busy=0, done=0.
  - Internal word index, lane index, node index and lane buffer cleared.
  - A partially completed copy is abandoned; no further writes are issued.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - On start=1, latch node_count, wm_base and om_base; clear node index n=0 and word index w=0.
  - If node_count=0, go to DONE with no memory access.
  - Otherwise go to LOAD.
  - start in any other state is ignored and not queued.
- LOAD (one cycle):
  - WMAR=(wm_base+w) mod 2^13.
  - At the clock edge, capture WMDR into the 128-bit lane buffer, set lane=0, go to WRITE.
  - OMWE=0 in this state.
- WRITE (one cycle per lane):
  - OMWE=1.
  - OMWAR=(om_base+n) mod 2^13.
  - OMWDR=buffer[16*lane+15 : 16*lane]; lane 0 is bits [15:0] and holds the lowest-numbered node.
  - At the edge, n increments. Then:
    - If n+1 == node_count, go to DONE.
    - Else if lane==7, increment w and go to LOAD.
    - Else increment lane and stay in WRITE.
  - A final partial word writes only node_count mod 8 lanes; upper lanes are discarded.
- DONE (one cycle): done=1, busy=0, OMWE=0; then go to IDLE.
- Timing: with start sampled at edge k, the first OMWE cycle is cycle k+2.
- Cycle cost: ceil(N/8) LOAD cycles plus N WRITE cycles, followed by 1 DONE cycle.
- WMAR holds its last driven value outside LOAD.
- OMWAR and OMWDR are don't-care when OMWE=0, but must not toggle to X.
- Distance values are copied bit-exact. 16'h7FFF (unreached node) and negative two's-complement values receive no special treatment.
- Address arithmetic wraps modulo 8192 on both memories; no error is flagged.
- node_count up to 8191 is supported. The n and w counters are 13 bits and must not overflow before node_count is reached.

Test Plan:
- Reset then start with node_count=10, wm_base=0x100, om_base=0x000. WM[0x100] holds lanes 0..7 = 1..8; WM[0x101] holds lanes 0..1 = 9,10.
  -> OM[0..9] = 1..10.
  -> 12 busy cycles (2 LOAD, 10 WRITE), then done high for exactly 1 cycle.
  -> OM[10] is not written.
- start with node_count=0.
  -> done pulses on the cycle after start; OMWE is never asserted; WMAR does not change.
- node_count=8.
  -> exactly 1 LOAD and 8 WRITE cycles; no second LOAD; lane 7 (bits [127:112]) lands at om_base+7.
- om_base=0x1FFE, node_count=4.
  -> writes land at 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- start pulsed again during WRITE.
  -> ignored; the copy completes unchanged and done pulses once.
- reset asserted on the 3rd WRITE cycle of a 16-node copy.
  -> OMWE=0 from the next cycle; only OM[om_base..om_base+2] are written; busy=0 and done=0. A new start after reset performs a full correct copy.

Source files
------------

// File: rtl/wm_result_writeback.sv
// Copies the final distance vector from Working Memory into Output Memory:
// one 128-bit word is loaded, then its 16-bit lanes are written one per cycle.
module wm_result_writeback (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [12:0]   node_count,
    input  logic [12:0]   wm_base,
    input  logic [12:0]   om_base,
    output logic [12:0]   WMAR,
    input  logic [127:0]  WMDR,
    output logic [12:0]   OMWAR,
    output logic [15:0]   OMWDR,
    output logic          OMWE,
    output logic          busy,
    output logic          done
);

    localparam int unsigned LANES = 8;
    localparam int unsigned AW    = 13;
    localparam int unsigned DW    = 16;
    localparam int unsigned LW    = $clog2(LANES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [AW-1:0]              cnt_q, cnt_d;
    logic [AW-1:0]              wm_base_q, wm_base_d;
    logic [AW-1:0]              om_base_q, om_base_d;
    logic [AW-1:0]              n_q, n_d;
    logic [AW-1:0]              w_q, w_d;
    logic [LW-1:0]              lane_q, lane_d;
    logic [LANES-1:0][DW-1:0]   buf_q, buf_d;
    logic [AW-1:0]              wmar_q, wmar_d;
    logic [AW-1:0]              omwar_q, omwar_d;
    logic [DW-1:0]              omwdr_q, omwdr_d;
    logic                       omwe_q, omwe_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [AW-1:0]              n_inc;
    logic [LW-1:0]              lane_inc;

    assign n_inc    = n_q + AW'(1);
    assign lane_inc = lane_q + LW'(1);

    // Next-state and registered-output computation; outputs are prepared one
    // cycle ahead so they are valid in the state they belong to.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wm_base_d = wm_base_q;
        om_base_d = om_base_q;
        n_d       = n_q;
        w_d       = w_q;
        lane_d    = lane_q;
        buf_d     = buf_q;
        wmar_d    = wmar_q;
        omwar_d   = omwar_q;
        omwdr_d   = omwdr_q;
        omwe_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d     = node_count;
                    wm_base_d = wm_base;
                    om_base_d = om_base;
                    n_d       = '0;
                    w_d       = '0;
                    if (node_count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                        wmar_d  = wm_base;
                    end
                end
            end
            S_LOAD: begin
                buf_d   = WMDR;
                lane_d  = '0;
                state_d = S_WRITE;
                omwe_d  = 1'b1;
                omwar_d = om_base_q + n_q;
                omwdr_d = WMDR[DW-1:0];
            end
            S_WRITE: begin
                n_d = n_inc;
                if (n_inc == cnt_q) begin
                    state_d = S_DONE;
                end else if (lane_q == LW'(LANES - 1)) begin
                    w_d     = w_q + AW'(1);
                    wmar_d  = wm_base_q + w_q + AW'(1);
                    state_d = S_LOAD;
                end else begin
                    lane_d  = lane_inc;
                    state_d = S_WRITE;
                    omwe_d  = 1'b1;
                    omwar_d = om_base_q + n_inc;
                    omwdr_d = buf_q[lane_inc];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_WRITE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wm_base_q <= '0;
            om_base_q <= '0;
            n_q       <= '0;
            w_q       <= '0;
            lane_q    <= '0;
            buf_q     <= '0;
            wmar_q    <= '0;
            omwar_q   <= '0;
            omwdr_q   <= '0;
            omwe_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wm_base_q <= wm_base_d;
            om_base_q <= om_base_d;
            n_q       <= n_d;
            w_q       <= w_d;
            lane_q    <= lane_d;
            buf_q     <= buf_d;
            wmar_q    <= wmar_d;
            omwar_q   <= omwar_d;
            omwdr_q   <= omwdr_d;
            omwe_q    <= omwe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign WMAR  = wmar_q;
    assign OMWAR = omwar_q;
    assign OMWDR = omwdr_q;
    assign OMWE  = omwe_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_wm_result_writeback.sv
// Bench for wm_result_writeback: memory arrays around the DUT, writes logged at
// the falling edge and compared against distances derived from node index.
module tb_wm_result_writeback;

    localparam int DEPTH = 8192;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [12:0]   node_count, wm_base, om_base;
    logic [12:0]   wmar, omwar;
    logic [127:0]  wmdr;
    logic [15:0]   omwdr;
    logic          omwe, busy, done;

    logic [127:0]  wm [DEPTH];
    logic [15:0]   om [DEPTH];
    bit            om_wr [DEPTH];
    int            wr_count;

    int checks = 0;
    int errors = 0;
    int busy_cyc, load_cyc, we_cyc, done_cyc, first_busy, first_we, timed_out;

    wm_result_writeback dut (
        .clock(clock), .reset(reset), .start(start),
        .node_count(node_count), .wm_base(wm_base), .om_base(om_base),
        .WMAR(wmar), .WMDR(wmdr), .OMWAR(omwar), .OMWDR(omwdr), .OMWE(omwe),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;
    assign wmdr = wm[wmar];

    // Distance of node i: lane i%8 of word wm_base + i/8.
    function automatic logic [15:0] exp_dist(input int i, input logic [12:0] wmb);
        logic [127:0] word;
        word = wm[(int'(wmb) + i / 8) % DEPTH];
        return word[16 * (i % 8) +: 16];
    endfunction

    function automatic int om_bad(input int n, input logic [12:0] wmb, input logic [12:0] omb);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            int a = (int'(omb) + i) % DEPTH;
            if (!om_wr[a] || om[a] !== exp_dist(i, wmb)) bad++;
        end
        return bad;
    endfunction

    task automatic clear_log();
        for (int i = 0; i < DEPTH; i++) begin
            om_wr[i] = 1'b0;
            om[i] = '0;
        end
        wr_count = 0; busy_cyc = 0; load_cyc = 0; we_cyc = 0; done_cyc = 0;
        first_busy = -1; first_we = -1; timed_out = 0;
    endtask

    // Called at a falling edge: records what the memory will see at the next rising edge.
    task automatic log_cycle(input int idx);
        if (busy) begin
            busy_cyc++;
            if (first_busy < 0) first_busy = idx;
            if (!omwe) load_cyc++;
        end
        if (omwe) begin
            we_cyc++;
            if (first_we < 0) first_we = idx;
            om[omwar] = omwdr;
            om_wr[omwar] = 1'b1;
            wr_count++;
        end
        if (done) done_cyc++;
    endtask

    task automatic run_copy(input int n, input logic [12:0] wmb, input logic [12:0] omb,
                            input int restart_at);
        int seen = 0;
        int extra = 0;
        int budget = n + n / 8 + 20;
        clear_log();
        @(negedge clock);
        start = 1'b1; node_count = 13'(n); wm_base = wmb; om_base = omb;
        for (int idx = 0; idx < budget; idx++) begin
            @(negedge clock);
            start = (idx == restart_at);
            if (idx == restart_at) begin
                node_count = 13'($urandom_range(1, 5));
                om_base = 13'($urandom);
                wm_base = 13'($urandom);
            end
            log_cycle(idx);
            if (seen != 0) extra++;
            if (done) seen = 1;
            if (extra == 3) break;
        end
        start = 1'b0;
        timed_out = (seen == 0);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; node_count = '0; wm_base = '0; om_base = '0;
        repeat (3) @(negedge clock);
        checks++; if ({omwe, busy, done} !== 3'b000) begin errors++;
            $display("FAIL reset_ctrl got %b exp 000", {omwe, busy, done}); end
        checks++; if ({wmar, omwar, omwdr} !== 42'd0) begin errors++;
            $display("FAIL reset_bus got %h/%h/%h exp 0", wmar, omwar, omwdr); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [127:0] w0, w1;
        w0 = '0; w1 = 128'($urandom) << 32;
        for (int l = 0; l < 8; l++) w0[16 * l +: 16] = 16'(l + 1);
        w1[15:0] = 16'd9; w1[31:16] = 16'd10;
        wm[13'h100] = w0; wm[13'h101] = w1;
        run_copy(10, 13'h100, 13'h000, -1);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL basic_timeout got 1 exp 0"); end
        checks++; if (om_bad(10, 13'h100, 13'h000) != 0) begin errors++;
            $display("FAIL basic_data bad %0d exp 0", om_bad(10, 13'h100, 13'h000)); end
        checks++; if (om[9] !== 16'd10) begin errors++; $display("FAIL basic_om9 got %0d exp 10", om[9]); end
        checks++; if (om_wr[10]) begin errors++; $display("FAIL basic_om10 got written exp untouched"); end
        checks++; if (busy_cyc != 12 || load_cyc != 2) begin errors++;
            $display("FAIL basic_cycles got busy %0d load %0d exp 12 2", busy_cyc, load_cyc); end
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL basic_done got %0d exp 1", done_cyc); end
        checks++; if (first_busy != 0 || first_we != 1) begin errors++;
            $display("FAIL basic_latency got %0d/%0d exp 0/1", first_busy, first_we); end
    endtask

    task automatic test_zero();
        logic [12:0] wmar_before;
        wmar_before = wmar;
        run_copy(0, 13'h055, 13'h0AA, -1);
        checks++; if (timed_out != 0 || first_busy != -1) begin errors++;
            $display("FAIL zero_done timeout %0d busy_at %0d exp 0 -1", timed_out, first_busy); end
        checks++; if (we_cyc != 0) begin errors++; $display("FAIL zero_we got %0d exp 0", we_cyc); end
        checks++; if (wmar !== wmar_before) begin errors++;
            $display("FAIL zero_wmar got %h exp %h", wmar, wmar_before); end
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_pulse got %0d exp 1", done_cyc); end
    endtask

    task automatic test_full_word();
        logic [12:0] wmb, omb;
        logic [127:0] word;
        wmb = 13'($urandom); omb = 13'($urandom_range(0, 8000));
        word = wm[wmb];
        run_copy(8, wmb, omb, -1);
        checks++; if (load_cyc != 1 || busy_cyc != 9) begin errors++;
            $display("FAIL full_cycles got load %0d busy %0d exp 1 9", load_cyc, busy_cyc); end
        checks++; if (om[omb + 13'd7] !== word[127:112]) begin errors++;
            $display("FAIL full_lane7 got %h exp %h", om[omb + 13'd7], word[127:112]); end
        checks++; if (wr_count != 8 || om_bad(8, wmb, omb) != 0) begin errors++;
            $display("FAIL full_data writes %0d bad %0d exp 8 0", wr_count, om_bad(8, wmb, omb)); end
    endtask

    task automatic test_wrap();
        logic [12:0] wmb;
        wmb = 13'h1FFF;
        run_copy(4, wmb, 13'h1FFE, -1);
        checks++; if (!(om_wr[13'h1FFE] && om_wr[13'h1FFF] && om_wr[0] && om_wr[1]) || wr_count != 4) begin
            errors++; $display("FAIL wrap_addr writes %0d exp 4 at 1ffe..0001", wr_count); end
        checks++; if (om[1] !== exp_dist(3, wmb)) begin errors++;
            $display("FAIL wrap_data got %h exp %h", om[1], exp_dist(3, wmb)); end
    endtask

    task automatic test_start_during_write();
        logic [12:0] wmb, omb;
        wmb = 13'($urandom); omb = 13'($urandom);
        run_copy(20, wmb, omb, 3);
        checks++; if (wr_count != 20 || om_bad(20, wmb, omb) != 0) begin errors++;
            $display("FAIL restart_data writes %0d bad %0d exp 20 0", wr_count, om_bad(20, wmb, omb)); end
        checks++; if (done_cyc != 1 || busy_cyc != 23) begin errors++;
            $display("FAIL restart_cycles done %0d busy %0d exp 1 23", done_cyc, busy_cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_queued got busy %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [12:0] wmb, omb;
        logic [2:0] after;
        int fired = 0;
        wmb = 13'($urandom); omb = 13'($urandom);
        after = 3'b111;
        clear_log();
        @(negedge clock);
        start = 1'b1; node_count = 13'd16; wm_base = wmb; om_base = omb;
        for (int idx = 0; idx < 40; idx++) begin
            @(negedge clock);
            start = 1'b0;
            log_cycle(idx);
            if (fired == 1) begin
                after = {omwe, busy, done};
                reset = 1'b0;
                fired = 2;
            end else if (fired == 0 && we_cyc == 3) begin
                reset = 1'b1;
                fired = 1;
            end
        end
        checks++; if (after !== 3'b000) begin errors++;
            $display("FAIL rstmid_ctrl got %b exp 000", after); end
        checks++; if (wr_count != 3 || om_bad(3, wmb, omb) != 0 || done_cyc != 0) begin errors++;
            $display("FAIL rstmid_writes writes %0d done %0d exp 3 0", wr_count, done_cyc); end
        run_copy(16, wmb, omb, -1);
        checks++; if (wr_count != 16 || om_bad(16, wmb, omb) != 0 || done_cyc != 1) begin errors++;
            $display("FAIL rstmid_recopy writes %0d done %0d exp 16 1", wr_count, done_cyc); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int n;
            logic [12:0] wmb, omb;
            n = (t == 7) ? 300 : int'($urandom_range(1, 70));
            wmb = 13'($urandom); omb = 13'($urandom);
            run_copy(n, wmb, omb, -1);
            checks++; if (timed_out != 0 || wr_count != n || om_bad(n, wmb, omb) != 0) begin errors++;
                $display("FAIL random_data n %0d writes %0d bad %0d exp %0d 0", n, wr_count,
                         om_bad(n, wmb, omb), n); end
            checks++; if (busy_cyc != (n + 7) / 8 + n || done_cyc != 1) begin errors++;
                $display("FAIL random_cycles n %0d busy %0d done %0d exp %0d 1", n, busy_cyc,
                         done_cyc, (n + 7) / 8 + n); end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++)
            wm[i] = {$urandom, $urandom, $urandom, $urandom};
        wm[13'h200] = {16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h1234, 16'hFFFE, 16'h0001};
        test_reset();
        test_basic();
        test_zero();
        test_full_word();
        test_wrap();
        test_start_during_write();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
